im_fetch: RTL and testbench

Instruction-memory responder for the fetch stage: it samples the word address and PC driven by the program-counter register, reads a 1024-word instruction array, and presents the instruction with its PC one cycle later as a registered, valid-qualified IF/ID handoff. It honours the same Stall that freezes the PC, supports a Flush for taken branches and jumps, and has a load port for the bench or boot loader to write program words.

---
 rtl/im_fetch.sv | 81 ++++++++
 tb/tb_im_fetch.sv | 137 +++++++++++++
 2 files changed

// File: rtl/im_fetch.sv
// Instruction-memory responder for the fetch stage: 2^AW-word array with a load port,
// presenting a registered, valid-qualified instruction/PC pair to the IF/ID boundary.
module im_fetch #(
  parameter int unsigned AW        = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [AW+1:2]  IMaddr,
  input  logic [31:0]    PC,
  input  logic           Stall,
  input  logic           Flush,
  input  logic           LoadEn,
  input  logic [AW+1:2]  LoadAddr,
  input  logic [31:0]    LoadData,
  output logic [31:0]    Instr,
  output logic [31:0]    InstrPC,
  output logic           InstrValid
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] rd_word;

  // Array is not touched by Reset; it starts out all zero.
  logic [31:0] mem_q [2**AW] = '{default: '0};

  always_ff @(posedge CLK) begin
    if (LoadEn) begin
      mem_q[LoadAddr] <= LoadData;
    end
  end

  // Same-edge load to the fetched address must be seen by the fetch.
  always_comb begin
    rd_word = mem_q[IMaddr];
    if (LoadEn && (LoadAddr == IMaddr)) begin
      rd_word = LoadData;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (Flush) begin
      instr_d = NOP_INSTR;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (!Stall) begin
      state_d = RUN;
      instr_d = rd_word;
      pc_d    = PC;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= BOOT;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign Instr      = instr_q;
  assign InstrPC    = pc_q;
  assign InstrValid = valid_q;

endmodule

// File: tb/tb_im_fetch.sv
// Directed self-checking bench for im_fetch: reset/boot, sequential fetch, stall,
// flush, load bypass and asynchronous mid-operation reset.
module tb_im_fetch;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [11:2] IMaddr;
  logic [31:0] PC;
  logic        Stall;
  logic        Flush;
  logic        LoadEn;
  logic [11:2] LoadAddr;
  logic [31:0] LoadData;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;

  int checks = 0;
  int errors = 0;

  im_fetch #(.AW(10), .NOP_INSTR(32'h0000_0000)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .IMaddr    (IMaddr),
    .PC        (PC),
    .Stall     (Stall),
    .Flush     (Flush),
    .LoadEn    (LoadEn),
    .LoadAddr  (LoadAddr),
    .LoadData  (LoadData),
    .Instr     (Instr),
    .InstrPC   (InstrPC),
    .InstrValid(InstrValid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                         input logic ev);
    chk({tag, "_instr"}, Instr, ei);
    chk({tag, "_pc"}, InstrPC, ep);
    chk({tag, "_valid"}, {31'b0, InstrValid}, {31'b0, ev});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1; IMaddr = '0; PC = '0; Stall = 1'b0; Flush = 1'b0;
    LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;

    // Reset with no clock edge yet
    #3;
    chk_out("reset", 32'h0, 32'h0, 1'b0);

    // Load mem[0] while Reset is still high
    LoadEn = 1'b1; LoadAddr = 10'd0; LoadData = 32'h2408_0001;
    step();
    chk_out("reset_hold", 32'h0, 32'h0, 1'b0);
    LoadEn = 1'b0; Reset = 1'b0; IMaddr = 10'd0; PC = 32'h3000;
    step();
    chk_out("boot", 32'h2408_0001, 32'h3000, 1'b1);

    // Program mem[0..3]
    for (int i = 0; i < 4; i++) begin
      LoadEn = 1'b1; LoadAddr = 10'(i); LoadData = 32'hA0 + 32'(i);
      step();
    end
    LoadEn = 1'b0;

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      IMaddr = 10'(i); PC = 32'h3000 + 32'(4 * i);
      step();
      chk_out($sformatf("seq%0d", i), 32'hA0 + 32'(i), 32'h3000 + 32'(4 * i), 1'b1);
    end

    // Stall for 3 edges while IMaddr moves
    Stall = 1'b1;
    IMaddr = 10'd1; PC = 32'h3004; step(); chk_out("stall0", 32'hA3, 32'h300C, 1'b1);
    IMaddr = 10'd2; PC = 32'h3008; step(); chk_out("stall1", 32'hA3, 32'h300C, 1'b1);
    IMaddr = 10'd0; PC = 32'h3000; step(); chk_out("stall2", 32'hA3, 32'h300C, 1'b1);
    Stall = 1'b0; IMaddr = 10'd2; PC = 32'h3008;
    step();
    chk_out("unstall", 32'hA2, 32'h3008, 1'b1);

    // Flush alone
    Flush = 1'b1; step(); chk_out("flush", 32'h0, 32'h0, 1'b0);
    Flush = 1'b0; IMaddr = 10'd1; PC = 32'h3004;
    step(); chk_out("post_flush", 32'hA1, 32'h3004, 1'b1);

    // Flush together with Stall: Flush wins
    Flush = 1'b1; Stall = 1'b1; step(); chk_out("flush_stall", 32'h0, 32'h0, 1'b0);
    Flush = 1'b0; Stall = 1'b0; IMaddr = 10'd3; PC = 32'h300C;
    step(); chk_out("post_flush2", 32'hA3, 32'h300C, 1'b1);

    // Same-edge load bypass to a never-written word
    LoadEn = 1'b1; LoadAddr = 10'd5; LoadData = 32'hDEAD_BEEF; IMaddr = 10'd5; PC = 32'h3014;
    step(); chk_out("bypass", 32'hDEAD_BEEF, 32'h3014, 1'b1);
    LoadEn = 1'b0; LoadData = '0;
    step(); chk_out("refetch5", 32'hDEAD_BEEF, 32'h3014, 1'b1);

    // Load during Stall still writes
    Stall = 1'b1; LoadEn = 1'b1; LoadAddr = 10'd6; LoadData = 32'h1234_5678;
    IMaddr = 10'd6; PC = 32'h3018;
    step(); chk_out("stall_load", 32'hDEAD_BEEF, 32'h3014, 1'b1);
    Stall = 1'b0; LoadEn = 1'b0; LoadData = '0;
    step(); chk_out("fetch6", 32'h1234_5678, 32'h3018, 1'b1);

    // Asynchronous reset between edges
    #2 Reset = 1'b1;
    #1 chk_out("async_rst", 32'h0, 32'h0, 1'b0);
    #1 Reset = 1'b0; IMaddr = 10'd2; PC = 32'h3008;
    step(); chk_out("after_rst", 32'hA2, 32'h3008, 1'b1);

    // Stalled edge in BOOT stays invalid, next clean edge fetches
    #2 Reset = 1'b1;
    #2 Reset = 1'b0; Stall = 1'b1; IMaddr = 10'd0; PC = 32'h3000;
    step(); chk_out("boot_stall", 32'h0, 32'h0, 1'b0);
    Stall = 1'b0;
    step(); chk_out("boot_exit", 32'hA0, 32'h3000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
